simd_bus_sequencer: RTL and testbench

//  Host-side controller that runs one complete SIMD MAC job over the 8-bit
//  CS/WR/RD/AD/excute bus of the SIMD engine. Writes the mode register and
//  the 64 operand registers (A lanes 0..31, B lanes 32..63) from a byte

---
 rtl/simd_bus_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_simd_bus_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_bus_sequencer.sv
// Host-side sequencer for one SIMD MAC job on the engine's CS/WR/RD/AD/excute bus:
// mode + 64 operand register writes, one execute strobe, then 32 result bytes out.
module simd_bus_sequencer #(
  parameter int LANES     = 32,
  parameter int BW        = 8,
  parameter int MODE_ADDR = 64,
  parameter int STB_W     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic          op_valid,
  input  logic [BW-1:0] op_data,
  output logic          op_ready,
  output logic          res_valid,
  output logic [BW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          done,
  output logic          simd_cs,
  output logic          simd_wr,
  output logic          simd_rd,
  output logic          simd_ad,
  output logic          simd_excute,
  output logic [BW-1:0] simd_dout,
  input  logic [BW-1:0] simd_din
);

  // Both streams: a byte moves on a clk edge where valid and ready are both high;
  // the valid side holds its data stable until that edge.

  localparam int            CW       = $clog2(STB_W + 2);
  localparam logic [CW-1:0] LAST_STB = CW'(STB_W);
  localparam logic [CW-1:0] HOLD     = CW'(STB_W + 1);
  localparam logic [6:0]    LAST_OP  = 7'(2 * LANES - 1);
  localparam logic [6:0]    LAST_RES = 7'(3 * LANES - 1);
  localparam logic [BW-1:0] MODE_A   = BW'(MODE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OP, S_WR, S_EXEC, S_SAMPLE, S_OUT, S_RD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [CW-1:0] stb_q, stb_d;
  logic          data_ph_q, data_ph_d;
  logic          wr_mode_q, wr_mode_d;
  logic [BW-1:0] wbyte_q, wbyte_d;
  logic [BW-1:0] res_data_q, res_data_d;
  logic          cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, ad_q, ad_d, ex_q, ex_d;
  logic          op_ready_q, op_ready_d, res_valid_q, res_valid_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [BW-1:0] dout_q, dout_d;
  logic          strobe_win;
  logic [BW-1:0] addr_byte;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stb_d      = stb_q;
    data_ph_d  = data_ph_q;
    wr_mode_d  = wr_mode_q;
    wbyte_d    = wbyte_q;
    res_data_d = res_data_q;
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      stb_d     = '0;
      data_ph_d = 1'b0;
      wr_mode_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          state_d   = S_WR;
          cnt_d     = '0;
          stb_d     = '0;
          data_ph_d = 1'b0;
          wr_mode_d = 1'b1;
          wbyte_d   = BW'(mode);
        end
        S_WAIT_OP: if (op_valid) begin
          wbyte_d   = op_data;
          stb_d     = '0;
          data_ph_d = 1'b0;
          state_d   = S_WR;
        end
        // Each register write is an address phase followed by a data phase.
        S_WR: if (stb_q == HOLD) begin
          stb_d = '0;
          if (!data_ph_q) begin
            data_ph_d = 1'b1;
          end else begin
            data_ph_d = 1'b0;
            if (wr_mode_q) begin
              wr_mode_d = 1'b0;
              state_d   = S_WAIT_OP;
            end else begin
              cnt_d   = cnt_q + 7'd1;
              state_d = (cnt_q == LAST_OP) ? S_EXEC : S_WAIT_OP;
            end
          end
        end else begin
          stb_d = stb_q + CW'(1);
        end
        S_EXEC: if (stb_q == LAST_STB) begin
          stb_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          stb_d = stb_q + CW'(1);
        end
        S_SAMPLE: begin
          res_data_d = simd_din;
          state_d    = S_OUT;
        end
        // The counter keeps climbing through the result bytes (64..95).
        S_OUT: if (res_ready) begin
          if (cnt_q == LAST_RES) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 7'd1;
            stb_d   = '0;
            state_d = S_RD;
          end
        end
        S_RD: if (stb_q == HOLD) begin
          stb_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          stb_d = stb_q + CW'(1);
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered pins track state_q exactly.
  always_comb begin
    strobe_win  = (stb_d != '0) && (stb_d <= LAST_STB);
    addr_byte   = wr_mode_d ? MODE_A : BW'(cnt_d);
    cs_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    wr_d        = (state_d == S_WR) && strobe_win;
    ad_d        = (state_d == S_WR) && !data_ph_d;
    dout_d      = (state_d == S_WR) ? (data_ph_d ? wbyte_d : addr_byte) : '0;
    rd_d        = (state_d == S_RD) && strobe_win;
    ex_d        = (state_d == S_EXEC) && (stb_d < LAST_STB);
    op_ready_d  = (state_d == S_WAIT_OP);
    res_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stb_q       <= '0;
      data_ph_q   <= 1'b0;
      wr_mode_q   <= 1'b0;
      wbyte_q     <= '0;
      res_data_q  <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      ad_q        <= 1'b0;
      ex_q        <= 1'b0;
      dout_q      <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      data_ph_q   <= data_ph_d;
      wr_mode_q   <= wr_mode_d;
      wbyte_q     <= wbyte_d;
      res_data_q  <= res_data_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ad_q        <= ad_d;
      ex_q        <= ex_d;
      dout_q      <= dout_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign simd_cs     = cs_q;
  assign simd_wr     = wr_q;
  assign simd_rd     = rd_q;
  assign simd_ad     = ad_q;
  assign simd_excute = ex_q;
  assign simd_dout   = dout_q;

endmodule

// File: tb/tb_simd_bus_sequencer.sv
// Bench for simd_bus_sequencer: a behavioural SIMD engine on the bus, stream drivers,
// and an expected-result queue computed from the operand arrays.
module tb_simd_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, op_valid, op_ready, res_valid, res_ready, busy, done;
  logic simd_cs, simd_wr, simd_rd, simd_ad, simd_excute;
  logic [1:0] mode;
  logic [7:0] op_data, res_data, simd_dout, simd_din;

  logic start3, abort3, op_valid3, op_ready3, res_valid3, res_ready3, busy3, done3;
  logic cs3, wr3, rd3, ad3, ex3;
  logic [1:0] mode3;
  logic [7:0] op_data3, res_data3, dout3, din3;

  simd_bus_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .done(done), .simd_cs(simd_cs), .simd_wr(simd_wr),
    .simd_rd(simd_rd), .simd_ad(simd_ad), .simd_excute(simd_excute),
    .simd_dout(simd_dout), .simd_din(simd_din)
  );

  simd_bus_sequencer #(.STB_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mode(mode3),
    .op_valid(op_valid3), .op_data(op_data3), .op_ready(op_ready3),
    .res_valid(res_valid3), .res_data(res_data3), .res_ready(res_ready3),
    .busy(busy3), .done(done3), .simd_cs(cs3), .simd_wr(wr3),
    .simd_rd(rd3), .simd_ad(ad3), .simd_excute(ex3),
    .simd_dout(dout3), .simd_din(din3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  ops [64];
  logic [7:0]  exp_q [$];
  logic [15:0] wr_log [$];

  // Engine MAC result per lane; the sequencer only moves the bytes.
  function automatic logic [7:0] mac(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      2'd0:    mac = 8'(a * b);
      2'd1:    mac = a + b;
      2'd2:    mac = 8'(a * b + a);
      default: mac = a ^ b;
    endcase
  endfunction

  logic [7:0] eng_reg [0:64];
  logic [7:0] eng_res [0:31];
  logic [7:0] eng_addr = 8'd0;
  logic mon_clr = 1'b0;
  logic wr_p = 1'b0, rd_p = 1'b0, ex_p = 1'b0, wr3_p = 1'b0, rd3_p = 1'b0, ex3_p = 1'b0;
  int wr_cnt = 0, rd_cnt = 0, ex_cnt = 0, done_cnt = 0, bad1 = 0;
  int wr3_cnt = 0, rd3_cnt = 0, ex3_cnt = 0, done3_cnt = 0, bad3 = 0;
  int w_wr = 0, w_rd = 0, w_ex = 0, w_wr3 = 0, w_rd3 = 0, w_ex3 = 0;

  assign simd_din = eng_res[0];
  assign din3     = 8'hA0 + 8'(rd3_cnt);

  // Engine model and bus monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt = 0; rd_cnt = 0; ex_cnt = 0; done_cnt = 0; bad1 = 0; wr_log.delete();
      wr3_cnt = 0; rd3_cnt = 0; ex3_cnt = 0; done3_cnt = 0; bad3 = 0;
    end else begin
      if (simd_wr && !wr_p) begin
        wr_cnt++;
        if (simd_ad) eng_addr = simd_dout;
        else begin
          if (eng_addr <= 8'd64) eng_reg[eng_addr] = simd_dout;
          wr_log.push_back({eng_addr, simd_dout});
        end
      end
      if (simd_excute && !ex_p) begin
        ex_cnt++;
        for (int i = 0; i < 32; i++) eng_res[i] = mac(eng_reg[64][1:0], eng_reg[i], eng_reg[32+i]);
      end
      if (simd_rd && !rd_p) begin
        rd_cnt++;
        for (int i = 0; i < 31; i++) eng_res[i] = eng_res[i+1];
      end
      if (done) done_cnt++;
      if (wr3 && !wr3_p) wr3_cnt++;
      if (rd3 && !rd3_p) rd3_cnt++;
      if (ex3 && !ex3_p) ex3_cnt++;
      if (done3) done3_cnt++;
    end
    if (!simd_wr && wr_p && w_wr != 1) bad1++;
    if (!simd_rd && rd_p && w_rd != 1) bad1++;
    if (!simd_excute && ex_p && w_ex != 1) bad1++;
    if (!wr3 && wr3_p && w_wr3 != 3) bad3++;
    if (!rd3 && rd3_p && w_rd3 != 3) bad3++;
    if (!ex3 && ex3_p && w_ex3 != 3) bad3++;
    w_wr  = simd_wr     ? w_wr + 1  : 0;
    w_rd  = simd_rd     ? w_rd + 1  : 0;
    w_ex  = simd_excute ? w_ex + 1  : 0;
    w_wr3 = wr3 ? w_wr3 + 1 : 0;
    w_rd3 = rd3 ? w_rd3 + 1 : 0;
    w_ex3 = ex3 ? w_ex3 + 1 : 0;
    wr_p = simd_wr; rd_p = simd_rd; ex_p = simd_excute;
    wr3_p = wr3; rd3_p = rd3; ex3_p = ex3;
  end

  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic feed(input int stall_idx, input int stall_cyc, input int abort_idx);
    int t;
    for (int idx = 0; idx < 64; idx++) begin
      op_data  = ops[idx];
      op_valid = (idx != stall_idx);
      t = 0;
      while (!op_ready && t < 200) begin @(negedge clk); t++; end
      if (!op_ready) begin
        n_checks++;
        $display("FAIL op_ready_timeout idx=%0d got op_ready=0 want 1", idx);
        op_valid = 1'b0;
        return;
      end
      if (idx == stall_idx) begin
        for (int k = 0; k < stall_cyc; k++) begin
          n_checks++;
          if (op_ready !== 1'b1 || simd_wr !== 1'b0)
            $display("FAIL op_stall_hold k=%0d got op_ready=%b wr=%b want 1/0", k, op_ready, simd_wr);
          else n_pass++;
          @(negedge clk);
        end
        op_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (idx == abort_idx) begin
        t = 0;
        while (!(simd_wr && !simd_ad) && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (!(simd_wr && !simd_ad)) $display("FAIL abort_find_strobe got wr=%b ad=%b want 1/0", simd_wr, simd_ad);
        else n_pass++;
        abort = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({simd_cs, simd_wr, simd_ad, busy, op_ready, res_valid} !== 6'b0)
          $display("FAIL abort_outputs got cs,wr,ad,busy,op_ready,res_valid=%b want 000000",
                   {simd_cs, simd_wr, simd_ad, busy, op_ready, res_valid});
        else n_pass++;
        return;
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic collect(input int res_stall);
    int t;
    logic [7:0] held, expv;
    res_ready = (res_stall == 0);
    for (int i = 0; i < 32; i++) begin
      t = 0;
      while (!res_valid && t < 2000) begin @(negedge clk); t++; end
      if (!res_valid) begin
        n_checks++;
        $display("FAIL res_valid_timeout byte=%0d got 0 want 1", i);
        res_ready = 1'b1;
        return;
      end
      expv = exp_q.pop_front();
      if (i == 0 && res_stall > 0) begin
        held = res_data;
        for (int k = 0; k < res_stall; k++) begin
          n_checks++;
          if (res_valid !== 1'b1 || res_data !== held || simd_rd !== 1'b0)
            $display("FAIL res_stall_hold k=%0d got valid=%b data=%h rd=%b want 1/%h/0",
                     k, res_valid, res_data, simd_rd, held);
          else n_pass++;
          @(negedge clk);
        end
        res_ready = 1'b1;
      end
      n_checks++;
      if (res_data !== expv) $display("FAIL res_byte[%0d] got %h want %h", i, res_data, expv);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input int stall_idx, input int stall_cyc,
                         input int res_stall, input int abort_idx, output int done_at);
    int n;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(mac(m, ops[i], ops[32+i]));
    clear_monitor();
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    done_at = -1;
    n = 1;
    fork
      feed(stall_idx, stall_cyc, abort_idx);
      if (abort_idx < 0) collect(res_stall);
      if (abort_idx < 0) begin
        while (!done && n < 3000) begin @(negedge clk); n++; end
        if (done) done_at = n;
      end
    join
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 64; i++) ops[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({simd_cs, simd_wr, simd_rd, simd_ad, simd_excute, op_ready, res_valid, busy, done} !== 9'b0)
      $display("FAIL reset_ctrl got %b want 000000000",
               {simd_cs, simd_wr, simd_rd, simd_ad, simd_excute, op_ready, res_valid, busy, done});
    else n_pass++;
    n_checks++;
    if ({simd_dout, res_data} !== 16'h0) $display("FAIL reset_data got %h want 0000", {simd_dout, res_data});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_abort_same_cycle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({busy, simd_cs} !== 2'b00) $display("FAIL start_abort_idle got busy,cs=%b want 00", {busy, simd_cs});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_bus_sequence();
    int d;
    logic [15:0] expp;
    for (int k = 0; k < 64; k++) ops[k] = 8'(k);
    run_job(2'd2, -1, 0, 0, -1, d);
    n_checks++;
    if (d !== 614) $display("FAIL seq_done_cycle got %0d want 614", d); else n_pass++;
    n_checks++;
    if (wr_log.size() !== 65) $display("FAIL seq_data_writes got %0d want 65", wr_log.size()); else n_pass++;
    for (int j = 0; j < wr_log.size() && j < 65; j++) begin
      expp = (j == 0) ? {8'd64, 8'd2} : {8'(j - 1), 8'(j - 1)};
      n_checks++;
      if (wr_log[j] !== expp) $display("FAIL seq_write[%0d] got %h want %h", j, wr_log[j], expp);
      else n_pass++;
    end
    n_checks++;
    if ({wr_cnt, ex_cnt, rd_cnt, done_cnt} !== {32'd130, 32'd1, 32'd31, 32'd1})
      $display("FAIL seq_pulse_counts got wr=%0d ex=%0d rd=%0d done=%0d want 130/1/31/1",
               wr_cnt, ex_cnt, rd_cnt, done_cnt);
    else n_pass++;
    n_checks++;
    if (bad1 !== 0) $display("FAIL seq_strobe_width got %0d bad want 0", bad1); else n_pass++;
  endtask

  task automatic test_op_stall();
    int d;
    randomize_ops();
    run_job(2'($urandom_range(0, 3)), 5, 10, 0, -1, d);
    n_checks++;
    if (d !== 624) $display("FAIL op_stall_done_cycle got %0d want 624", d); else n_pass++;
  endtask

  task automatic test_res_stall();
    int d;
    randomize_ops();
    run_job(2'($urandom_range(0, 3)), -1, 0, 5, -1, d);
    n_checks++;
    if (d !== 619) $display("FAIL res_stall_done_cycle got %0d want 619", d); else n_pass++;
    n_checks++;
    if (rd_cnt !== 31) $display("FAIL res_stall_rd_count got %0d want 31", rd_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    int d;
    randomize_ops();
    run_job(2'd1, -1, 0, 0, 49, d);
    repeat (5) @(negedge clk);
    n_checks++;
    if ({done_cnt != 0, busy} !== 2'b00) $display("FAIL abort_no_done got done_cnt=%0d busy=%b want 0/0", done_cnt, busy);
    else n_pass++;
    randomize_ops();
    run_job(2'd3, -1, 0, 0, -1, d);
    n_checks++;
    if (d !== 614) $display("FAIL after_abort_done_cycle got %0d want 614", d); else n_pass++;
  endtask

  task automatic test_random_jobs();
    int d, si, sc, rs;
    repeat (2) begin
      randomize_ops();
      si = $urandom_range(0, 63);
      sc = $urandom_range(1, 8);
      rs = $urandom_range(0, 6);
      run_job(2'($urandom_range(0, 3)), si, sc, rs, -1, d);
      n_checks++;
      if (d !== 614 + sc + rs) $display("FAIL rand_done_cycle got %0d want %0d", d, 614 + sc + rs);
      else n_pass++;
      n_checks++;
      if ({done_cnt, bad1} !== {32'd1, 32'd0}) $display("FAIL rand_done_width got done=%0d bad=%0d want 1/0", done_cnt, bad1);
      else n_pass++;
    end
  endtask

  task automatic test_stb3_double_start();
    int n, idx;
    logic [7:0] expv;
    clear_monitor();
    mode3 = 2'd1;
    op_valid3 = 1'b1;
    op_data3 = 8'h11;
    res_ready3 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 1;
    idx = 0;
    while (!done3 && n < 3000) begin
      start3 = (n == 50);
      if (res_valid3) begin
        expv = 8'hA0 + 8'(idx);
        n_checks++;
        if (res_data3 !== expv) $display("FAIL stb3_res[%0d] got %h want %h", idx, res_data3, expv);
        else n_pass++;
        idx++;
      end
      @(negedge clk);
      n++;
    end
    start3 = 1'b0;
    op_valid3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (n !== 938) $display("FAIL stb3_done_cycle got %0d want 938", n); else n_pass++;
    n_checks++;
    if ({idx, done3_cnt, wr3_cnt, rd3_cnt, ex3_cnt} !== {32'd32, 32'd1, 32'd130, 32'd31, 32'd1})
      $display("FAIL stb3_counts got res=%0d done=%0d wr=%0d rd=%0d ex=%0d want 32/1/130/31/1",
               idx, done3_cnt, wr3_cnt, rd3_cnt, ex3_cnt);
    else n_pass++;
    n_checks++;
    if (bad3 !== 0) $display("FAIL stb3_strobe_width got %0d bad want 0", bad3); else n_pass++;
  endtask

  task automatic test_reset_mid_rd();
    int t;
    randomize_ops();
    clear_monitor();
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b1;
    feed(-1, 0, -1);
    t = 0;
    while (!simd_rd && t < 300) begin @(negedge clk); t++; end
    n_checks++;
    if (!simd_rd) $display("FAIL mid_rd_find got rd=0 want 1"); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({simd_cs, simd_wr, simd_rd, simd_ad, simd_excute, op_ready, res_valid, busy, done} !== 9'b0)
      $display("FAIL mid_rd_reset got %b want 000000000",
               {simd_cs, simd_wr, simd_rd, simd_ad, simd_excute, op_ready, res_valid, busy, done});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    op_valid = 1'b0; op_data = 8'h0; res_ready = 1'b1;
    start3 = 1'b0; abort3 = 1'b0; mode3 = 2'd0;
    op_valid3 = 1'b0; op_data3 = 8'h0; res_ready3 = 1'b1;
    for (int i = 0; i < 65; i++) eng_reg[i] = 8'h0;
    for (int i = 0; i < 32; i++) eng_res[i] = 8'h0;
    test_reset();
    test_start_abort_same_cycle();
    test_bus_sequence();
    test_op_stall();
    test_res_stall();
    test_abort();
    test_random_jobs();
    test_stb3_double_start();
    test_reset_mid_rd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
